// File: rtl/reaction_measure.sv
// Reaction-time measurement stage: lights the LED on go, counts ms until press.
// Optional best-score register enabled by defining REACTION_BEST_SCORE_EN.
module reaction_measure #(
  parameter int TICKS_PER_MS = 50000,
  parameter int CNT_W        = 14,
  parameter int MAX_MS       = 9999
) (
  input  logic             clock1,
  input  logic             resetn,
  input  logic             start,
  input  logic             go,
  input  logic             press,
  output logic             led,
  output logic [CNT_W-1:0] rt_ms,
  output logic             rt_valid,
  output logic [CNT_W-1:0] best_ms,
  output logic             false_start,
  output logic             timeout,
  output logic             busy
);

  localparam int               PS_W    = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICKS_PER_MS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_MS);

  typedef enum logic [2:0] {IDLE, ARMED, MEASURE, DONE, FAULT} state_t;

  state_t           state;
  state_t           state_next;
  logic             start_q;
  logic             press_q;
  logic             start_rise;
  logic             press_rise;
  logic [PS_W-1:0]  presc;
  logic [CNT_W-1:0] ms_cnt;
  logic [CNT_W-1:0] ms_next;
  logic             wrap;
  logic             sat;
  logic             timeout_q;

  // ms_next already includes the tick completing in this cycle, so a press
  // on a wrap cycle reports the millisecond that has just finished.
  always_comb begin
    start_rise = start & ~start_q;
    press_rise = press & ~press_q;
    wrap       = (presc == PS_LAST);
    ms_next    = wrap ? ms_cnt + CNT_W'(1) : ms_cnt;
    sat        = (ms_next == MAX_CNT);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, FAULT: if (start_rise) state_next = ARMED;
      ARMED: begin
        if (press_rise)  state_next = FAULT;
        else if (go)     state_next = MEASURE;
      end
      MEASURE: if (press_rise || sat) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock1) begin
    if (!resetn) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      press_q   <= 1'b0;
      presc     <= '0;
      ms_cnt    <= '0;
      rt_ms     <= '0;
      rt_valid  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state    <= state_next;
      start_q  <= start;
      press_q  <= press;
      rt_valid <= 1'b0;
      case (state)
        IDLE, DONE, FAULT: if (start_rise) timeout_q <= 1'b0;
        ARMED: begin
          if (!press_rise && go) begin
            presc  <= '0;
            ms_cnt <= '0;
          end
        end
        MEASURE: begin
          presc  <= wrap ? '0 : presc + PS_W'(1);
          ms_cnt <= ms_next;
          // A press on the saturating cycle is still a valid result.
          if (press_rise) begin
            rt_ms    <= ms_next;
            rt_valid <= 1'b1;
          end else if (sat) begin
            rt_ms     <= MAX_CNT;
            timeout_q <= 1'b1;
            rt_valid  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef REACTION_BEST_SCORE_EN
  logic [CNT_W-1:0] best_q;

  always_ff @(posedge clock1) begin
    if (!resetn) begin
      best_q <= MAX_CNT;
    end else if (state == MEASURE && press_rise && ms_next < best_q) begin
      best_q <= ms_next;
    end
  end

  assign best_ms = best_q;
`else
  assign best_ms = MAX_CNT;
`endif

  assign led         = (state == MEASURE);
  assign busy        = (state == ARMED) || (state == MEASURE);
  assign false_start = (state == FAULT);
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_reaction_measure.sv
// Directed testbench for reaction_measure (TICKS_PER_MS=4, MAX_MS=30).
module tb_reaction_measure;

  localparam int TPM   = 4;
  localparam int CNT_W = 14;
  localparam int MAXMS = 30;

  typedef struct {
    int press_cycles;
    int exp_rt;
    int exp_timeout;
    int exp_best;
    int exp_led_cycles;
  } vec_t;

  logic             clock1;
  logic             resetn;
  logic             start;
  logic             go;
  logic             press;
  logic             led;
  logic [CNT_W-1:0] rt_ms;
  logic             rt_valid;
  logic [CNT_W-1:0] best_ms;
  logic             false_start;
  logic             timeout;
  logic             busy;

  int checks = 0;
  int errors = 0;

  reaction_measure #(
    .TICKS_PER_MS(TPM),
    .CNT_W(CNT_W),
    .MAX_MS(MAXMS)
  ) dut (
    .clock1(clock1),
    .resetn(resetn),
    .start(start),
    .go(go),
    .press(press),
    .led(led),
    .rt_ms(rt_ms),
    .rt_valid(rt_valid),
    .best_ms(best_ms),
    .false_start(false_start),
    .timeout(timeout),
    .busy(busy)
  );

  initial begin
    clock1 = 1'b0;
    forever #5 clock1 = ~clock1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic s, input logic g, input logic p);
    start = s;
    go    = g;
    press = p;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int expBest(input int with_macro);
`ifdef REACTION_BEST_SCORE_EN
    return with_macro;
`else
    return (with_macro >= 0) ? MAXMS : MAXMS;
`endif
  endfunction

  task automatic runRound(input vec_t v);
    int led_cnt;
    int done;
    led_cnt = 0;
    done    = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clock1);
    checkOutput("armed_busy", int'(busy), 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    if (v.press_cycles > 0) begin
      for (int i = 0; i < v.press_cycles; i++) begin
        @(negedge clock1);
        if (led) led_cnt++;
      end
      applyStimulus(1'b0, 1'b1, 1'b1);
      @(negedge clock1);
    end else begin
      for (int i = 0; i < 400; i++) begin
        @(negedge clock1);
        if (!led) begin
          done = 1;
          break;
        end
        led_cnt++;
      end
      checkOutput("timeout_reached", done, 1);
    end
    checkOutput("led_cycles", led_cnt, v.exp_led_cycles);
    checkOutput("rt_valid_pulse", int'(rt_valid), 1);
    checkOutput("rt_ms", int'(rt_ms), v.exp_rt);
    checkOutput("timeout_flag", int'(timeout), v.exp_timeout);
    checkOutput("done_led_off", int'(led), 0);
    checkOutput("done_busy", int'(busy), 0);
    checkOutput("best_ms", int'(best_ms), expBest(v.exp_best));
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clock1);
    checkOutput("rt_valid_single", int'(rt_valid), 0);
    checkOutput("rt_ms_hold", int'(rt_ms), v.exp_rt);
  endtask

  initial begin
    vec_t vecs[6];
    int   led_seen;
    int   led_low_seen;
    int   rv_seen;
    int   busy_seen;

    vecs[0] = '{60,  15,    0, 15, 60};
    vecs[1] = '{100, 25,    0, 15, 100};
    vecs[2] = '{48,  12,    0, 12, 48};
    vecs[3] = '{0,   MAXMS, 1, 12, 120};
    vecs[4] = '{40,  10,    0, 10, 40};
    vecs[5] = '{42,  10,    0, 10, 42};

    resetn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clock1);
    checkOutput("rst_led", int'(led), 0);
    checkOutput("rst_rt_ms", int'(rt_ms), 0);
    checkOutput("rst_rt_valid", int'(rt_valid), 0);
    checkOutput("rst_best", int'(best_ms), MAXMS);
    checkOutput("rst_false_start", int'(false_start), 0);
    checkOutput("rst_timeout", int'(timeout), 0);
    checkOutput("rst_busy", int'(busy), 0);
    resetn = 1'b1;
    @(negedge clock1);

    foreach (vecs[i]) runRound(vecs[i]);

    // False start, with go raised together with the press.
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clock1);
    checkOutput("fs_armed_busy", int'(busy), 1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    @(negedge clock1);
    checkOutput("fs_flag", int'(false_start), 1);
    checkOutput("fs_busy", int'(busy), 0);
    checkOutput("fs_rt_valid", int'(rt_valid), 0);
    checkOutput("fs_rt_ms", int'(rt_ms), 10);
    led_seen = 0;
    rv_seen  = 0;
    repeat (5) begin
      @(negedge clock1);
      if (led) led_seen = 1;
      if (rt_valid) rv_seen = 1;
    end
    checkOutput("fs_led_never", led_seen, 0);
    checkOutput("fs_no_valid", rv_seen, 0);
    checkOutput("fs_flag_hold", int'(false_start), 1);
    checkOutput("fs_best_hold", int'(best_ms), expBest(10));
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clock1);
    checkOutput("fs_cleared", int'(false_start), 0);
    checkOutput("fs_rearm_busy", int'(busy), 1);

    // Reset while measuring, then stray go/press must be ignored.
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(negedge clock1);
    checkOutput("mid_led_on", int'(led), 1);
    repeat (3) @(negedge clock1);
    resetn = 1'b0;
    @(negedge clock1);
    checkOutput("mid_rst_led", int'(led), 0);
    checkOutput("mid_rst_rt_ms", int'(rt_ms), 0);
    checkOutput("mid_rst_rt_valid", int'(rt_valid), 0);
    checkOutput("mid_rst_best", int'(best_ms), MAXMS);
    checkOutput("mid_rst_false_start", int'(false_start), 0);
    checkOutput("mid_rst_timeout", int'(timeout), 0);
    checkOutput("mid_rst_busy", int'(busy), 0);
    resetn = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1);
    @(negedge clock1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    led_seen  = 0;
    rv_seen   = 0;
    busy_seen = 0;
    repeat (4) begin
      @(negedge clock1);
      if (led) led_seen = 1;
      if (rt_valid) rv_seen = 1;
      if (busy) busy_seen = 1;
    end
    checkOutput("post_rst_led", led_seen, 0);
    checkOutput("post_rst_valid", rv_seen, 0);
    checkOutput("post_rst_busy", busy_seen, 0);

    // Press held from IDLE through start and go is not a false start.
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge clock1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clock1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    @(negedge clock1);
    checkOutput("held_led_on", int'(led), 1);
    checkOutput("held_no_fs", int'(false_start), 0);
    led_low_seen = 0;
    repeat (8) begin
      @(negedge clock1);
      if (!led) led_low_seen = 1;
    end
    checkOutput("held_stays_measure", led_low_seen, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(negedge clock1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    @(negedge clock1);
    checkOutput("held_rt_valid", int'(rt_valid), 1);
    checkOutput("held_rt_ms", int'(rt_ms), 2);
    checkOutput("held_led_off", int'(led), 0);
    checkOutput("held_best", int'(best_ms), expBest(2));
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clock1);
    checkOutput("held_valid_single", int'(rt_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
